// File: rtl/mem_port_arbiter.sv
// Shares one block-wide main-memory port between the icache (block reads) and dcache (block reads and write-backs).
// Define MEM_ARB_ROUND_ROBIN_EN to break simultaneous requests by last winner instead of fixed dcache priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;
  logic   d_req_s;
  logic   pick_d_s;

  assign d_req_s = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_r;

  // Remembers whether the most recent grant went to the dcache; resets to icache-last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_d_r <= 1'b0;
    end else if ((state_r == IDLE) && (d_req_s || i_read)) begin
      last_d_r <= pick_d_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end

  assign pick_d_s = d_req_s & (~i_read | ~last_d_r);
`else
  assign pick_d_s = d_req_s;
`endif

  // Arbitration state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_d_s) begin
          state_s = GRANT_D;
        end else if (i_read) begin
          state_s = GRANT_I;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_I: begin
        if (!mem_busywait) begin
          state_s = DONE_I;
        end else begin
          state_s = GRANT_I;
        end
      end
      GRANT_D: begin
        if (!mem_busywait) begin
          state_s = DONE_D;
        end else begin
          state_s = GRANT_D;
        end
      end
      DONE_I:  state_s = IDLE;
      DONE_D:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory-side request registers are loaded only at grant, so requesters cannot disturb an access in flight.
  // The strobe registers double as the latched direction; a dcache write wins over a simultaneous read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_d_s) begin
            mem_address <= d_address;
            mem_read    <= ~d_write;
            mem_write   <= d_write;
            if (d_write) begin
              mem_writedata <= d_writedata;
            end
          end else if (i_read) begin
            mem_address <= i_address;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
          end
        end
        GRANT_I: begin
          if (!mem_busywait) begin
            mem_read   <= 1'b0;
            i_readdata <= mem_readdata;
          end
        end
        GRANT_D: begin
          if (!mem_busywait) begin
            if (mem_read) begin
              d_readdata <= mem_readdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign i_busywait = i_read  & (state_r != DONE_I);
  assign d_busywait = d_req_s & (state_r != DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-timeline reference model.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam logic [127:0] T3_RD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] T3_WD = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         i_read = 1'b0;
  logic [27:0]  i_address = '0;
  logic [127:0] i_readdata;
  logic         i_busywait;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [27:0]  d_address = '0;
  logic [127:0] d_writedata = '0;
  logic [127:0] d_readdata;
  logic         d_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_checks = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(28), .BLOCK_W(128)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory: each access stays busy for a chosen number of strobe cycles and returns a chosen block.
  int           force_lat = 1;
  bit           use_force_rd = 1'b0;
  logic [127:0] force_rd = '0;
  int           lat_tab [8];
  logic [127:0] rd_tab [16];
  int           mem_cnt;
  logic [31:0]  mem_idx;
  logic         junk_bit = 1'b0;
  logic         strobe;
  int           cur_lat;
  logic [127:0] cur_rd;

  assign strobe       = mem_read | mem_write;
  assign cur_lat      = (force_lat != 0) ? force_lat : lat_tab[mem_idx[2:0]];
  assign cur_rd       = use_force_rd ? force_rd : rd_tab[mem_idx[3:0]];
  assign mem_busywait = strobe ? (mem_cnt + 1 < cur_lat) : junk_bit;
  assign mem_readdata = (strobe && mem_busywait) ? ~cur_rd : cur_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_cnt <= 0;
      mem_idx <= '0;
    end else if (strobe) begin
      if (mem_cnt + 1 >= cur_lat) begin
        mem_cnt <= 0;
        mem_idx <= mem_idx + 32'd1;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  always @(negedge clock) junk_bit <= 1'($urandom);

  function automatic int lat_of(input int k);
    return (force_lat != 0) ? force_lat : lat_tab[k % 8];
  endfunction

  function automatic logic [127:0] rd_of(input int k);
    return use_force_rd ? force_rd : rd_tab[k % 16];
  endfunction

  // Reference model: one transaction at a time, timed as grant + latency, then one done cycle and one idle cycle.
  int           m_owner = 0;
  int           m_left = 0;
  int           m_done_who = 0;
  int           m_acc = 0;
  bit           m_idle_gap = 1'b0;
  bit           m_op_read = 1'b0;
  bit           m_last_d = 1'b0;
  bit           dq, take_d;
  logic         m_read = 1'b0, m_write = 1'b0;
  logic [27:0]  m_addr = '0;
  logic [127:0] m_wdata = '0, m_ird = '0, m_drd = '0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_owner = 0; m_left = 0; m_done_who = 0; m_acc = 0;
        m_idle_gap = 1'b0; m_op_read = 1'b0; m_last_d = 1'b0;
        m_read = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
      end else begin
        m_done_who = 0;
        if (m_owner != 0) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_op_read) begin
              if (m_owner == 1) m_ird = rd_of(m_acc);
              else m_drd = rd_of(m_acc);
            end
            m_acc = m_acc + 1;
            m_read = 1'b0; m_write = 1'b0;
            m_done_who = m_owner;
            m_owner = 0;
            m_idle_gap = 1'b1;
          end
        end else if (m_idle_gap) begin
          m_idle_gap = 1'b0;
        end else begin
          dq = d_read | d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (dq && i_read) take_d = !m_last_d;
          else take_d = dq;
`else
          take_d = dq;
`endif
          if (take_d) begin
            m_owner = 2; m_addr = d_address; m_left = lat_of(m_acc); m_last_d = 1'b1;
            if (d_write) begin
              m_write = 1'b1; m_read = 1'b0; m_wdata = d_writedata; m_op_read = 1'b0;
            end else begin
              m_read = 1'b1; m_write = 1'b0; m_op_read = 1'b1;
            end
          end else if (i_read) begin
            m_owner = 1; m_addr = i_address; m_left = lat_of(m_acc); m_last_d = 1'b0;
            m_read = 1'b1; m_write = 1'b0; m_op_read = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("mem_read", 128'(mem_read), 128'(m_read));
        chk("mem_write", 128'(mem_write), 128'(m_write));
        chk("mem_address", 128'(mem_address), 128'(m_addr));
        chk("mem_writedata", mem_writedata, m_wdata);
        chk("i_readdata", i_readdata, m_ird);
        chk("d_readdata", d_readdata, m_drd);
        chk("i_busywait", 128'(i_busywait), 128'(i_read && (m_done_who != 1)));
        chk("d_busywait", 128'(d_busywait), 128'((d_read || d_write) && (m_done_who != 2)));
      end
    end
  end

  task automatic wait_low(input bit side_d, input string name);
    bit fell;
    fell = 1'b0;
    for (int n = 0; n < 60 && !fell; n++) begin
      @(negedge clock);
      fell = side_d ? !d_busywait : !i_busywait;
    end
    chk({name, " completes"}, 128'(fell), 128'd1);
  endtask

  int cyc, hi;
  bit dbw, fell, ib_drop, prev_strobe, busy_any;
  logic [5:0] order;

  initial begin
    for (int k = 0; k < 8; k++) lat_tab[k] = $urandom_range(1, 6);
    for (int k = 0; k < 16; k++) rd_tab[k] = {$urandom, $urandom, $urandom, $urandom};

    @(posedge clock); @(posedge clock); @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset i_readdata", i_readdata, 128'd0);
    chk("reset d_readdata", d_readdata, 128'd0);
    chk("reset mem_read", 128'(mem_read), 128'd0);
    chk("reset mem_write", 128'(mem_write), 128'd0);
    chk("reset mem_address", 128'(mem_address), 128'd0);
    chk("reset mem_writedata", mem_writedata, 128'd0);
    chk("reset busywaits", 128'({i_busywait, d_busywait}), 128'd0);

    // Single icache read: 5 busy cycles, A5 pattern.
    force_lat = 5; use_force_rd = 1'b1; force_rd = {16{8'hA5}};
    @(posedge clock); #1;
    i_read = 1'b1; i_address = 28'h0000010;
    cyc = 1; hi = 0; dbw = 1'b0; fell = 1'b0;
    for (int k = 0; k < 40 && !fell; k++) begin
      @(negedge clock);
      if (mem_read) hi++;
      if (d_busywait) dbw = 1'b1;
      if (!i_busywait) fell = 1'b1;
      else begin @(posedge clock); cyc++; end
    end
    #1 i_read = 1'b0;
    chk("t1 busywait fall cycle", 128'(cyc), 128'd7);
    chk("t1 mem_read cycles", 128'(hi), 128'd5);
    chk("t1 i_readdata", i_readdata, {16{8'hA5}});
    chk("t1 d_busywait quiet", 128'(dbw), 128'd0);

    // Reset during the second busy cycle of an icache read.
    force_lat = 3; force_rd = {16{8'h3C}};
    @(posedge clock); #1;
    i_read = 1'b1; i_address = 28'h0000010;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("t2 mem_read on reset", 128'(mem_read), 128'd0);
    chk("t2 i_readdata on reset", i_readdata, 128'd0);
    chk("t2 mem_address on reset", 128'(mem_address), 128'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("t2 regrant mem_read", 128'(mem_read), 128'd1);
    chk("t2 regrant mem_address", 128'(mem_address), 128'h0000010);
    wait_low(1'b0, "t2 read");
    #1 i_read = 1'b0;
    chk("t2 i_readdata", i_readdata, {16{8'h3C}});

    // dcache read, then a write-back that must leave d_readdata alone.
    force_lat = 1; force_rd = T3_RD;
    @(posedge clock); #1;
    d_read = 1'b1; d_address = 28'h0000022;
    wait_low(1'b1, "t3 read");
    #1 d_read = 1'b0;
    chk("t3 d_readdata", d_readdata, T3_RD);
    force_lat = 2;
    @(posedge clock); #1;
    d_write = 1'b1; d_address = 28'h0ABCDEF; d_writedata = T3_WD;
    @(posedge clock); #1;
    chk("t3 mem_write", 128'(mem_write), 128'd1);
    chk("t3 mem_read", 128'(mem_read), 128'd0);
    chk("t3 mem_writedata", mem_writedata, T3_WD);
    chk("t3 mem_address", 128'(mem_address), 128'h0ABCDEF);
    wait_low(1'b1, "t3 write");
    #1 d_write = 1'b0;
    chk("t3 d_readdata kept", d_readdata, T3_RD);

    // Address change while the dcache holds the grant.
    force_lat = 4;
    @(posedge clock); #1;
    d_read = 1'b1; d_address = 28'h0000055;
    @(posedge clock); #1;
    d_address = 28'h0000066;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t5 mem_address held", 128'(mem_address), 128'h0000055);
    end
    wait_low(1'b1, "t5 read");
    #1 d_read = 1'b0;

    // Three simultaneous-request rounds from a fresh reset.
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); @(negedge clock); reset = 1'b0;
    force_lat = 3; use_force_rd = 1'b0;
    order = '0; ib_drop = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(posedge clock); #1;
      i_read = 1'b1; d_read = 1'b1;
      i_address = 28'h0000100 + 28'(r); d_address = 28'h0000200 + 28'(r);
      prev_strobe = 1'b0;
      for (int k = 0; k < 60 && (i_read || d_read); k++) begin
        @(posedge clock); #1;
        if (strobe && !prev_strobe) order = {order[4:0], (mem_address == d_address)};
        prev_strobe = strobe;
        if (strobe && (mem_address == d_address) && !i_busywait) ib_drop = 1'b1;
        if (i_read && !i_busywait) i_read = 1'b0;
        if (d_read && !d_busywait) d_read = 1'b0;
      end
      chk("t4 round drained", 128'({i_read, d_read}), 128'd0);
      i_read = 1'b0; d_read = 1'b0;
    end
    chk("t4 grant order DIDIDI", 128'(order), 128'(6'b101010));
    chk("t4 i_busywait held", 128'(ib_drop), 128'd0);

    // Randomised traffic with varying memory latency.
    force_lat = 0;
    for (int cyc_r = 0; cyc_r < 3000; cyc_r++) begin
      @(posedge clock); #1;
      if (i_read) begin
        if (!i_busywait) i_read = 1'b0;
      end else if ($urandom_range(0, 99) < 30) begin
        i_read = 1'b1; i_address = 28'($urandom);
      end
      if (d_read || d_write) begin
        if (!d_busywait) begin d_read = 1'b0; d_write = 1'b0; end
      end else if ($urandom_range(0, 99) < 30) begin
        hi = int'($urandom_range(0, 99));
        d_write = (hi < 40) || (hi >= 95);
        d_read = (hi >= 40);
        d_address = 28'($urandom);
        d_writedata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    busy_any = 1'b1;
    for (int k = 0; k < 100 && busy_any; k++) begin
      @(posedge clock); #1;
      if (i_read && !i_busywait) i_read = 1'b0;
      if ((d_read || d_write) && !d_busywait) begin d_read = 1'b0; d_write = 1'b0; end
      busy_any = i_read || d_read || d_write;
    end
    chk("random drained", 128'(busy_any), 128'd0);
    repeat (4) @(posedge clock);
    #1;
    chk("access count", 128'(mem_idx), 128'(m_acc));
    chk("random traffic served", 128'(m_acc > 200), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single 128-bit-block main-memory port between the instruction-cache controller and the data-cache controller. Sits between both cache controllers and main memory. Serialises block reads (both requesters) and block write-backs (data side only), holds each loser stalled via its busywait, and returns each fetched block to the requester that asked for it.

## Interface
Parameters:
- ADDR_W, 28, block-address width (word address >> 2).
- BLOCK_W, 128, block width in bits.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- i_read  in  1  icache block-read request
- i_address  in  ADDR_W  icache block address
- i_readdata  out  BLOCK_W  block returned to icache
- i_busywait  out  1  icache stall
- d_read  in  1  dcache block-read request
- d_write  in  1  dcache write-back request
- d_address  in  ADDR_W  dcache block address
- d_writedata  in  BLOCK_W  dcache write-back block
- d_readdata  out  BLOCK_W  block returned to dcache
- d_busywait  out  1  dcache stall
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory block address
- mem_writedata  out  BLOCK_W  memory write data
- mem_readdata  in  BLOCK_W  memory read data
- mem_busywait  in  1  memory busy; falls when the access is complete

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
- IDLE:
  - Sample requests at posedge.
  - d_read or d_write set, i_read clear: go to GRANT_D.
  - Only i_read set: go to GRANT_I.
  - Both set: dcache wins (fixed priority; see Configuration).
- On entry to GRANT_x, register the winner's address and, for a write, its data and direction. mem_* outputs are driven from these registers only, so a requester changing its inputs mid-access does not disturb memory.
- GRANT_I drives mem_read=1. GRANT_D drives mem_read=d_read or mem_write=d_write, as latched.
- d_read and d_write both high is illegal. The arbiter latches the write and ignores the read.
- GRANT_x stays until mem_busywait is sampled 0 at posedge, then goes to DONE_x.
- On that same edge, mem_readdata is latched into i_readdata or d_readdata. Each output holds its value until the next completed read for that requester.
- DONE_x: mem_read=mem_write=0, the requester's busywait=0. Go to IDLE next edge.
- Busywait outputs (combinational):
  - i_busywait = i_read & !(state==DONE_I).
  - d_busywait = (d_read|d_write) & !(state==DONE_D).
- Requester rule: hold the request and address until busywait falls, and deassert within the DONE cycle. A request withdrawn before grant is simply dropped.
- Reset at any time (async) forces IDLE, all mem_* strobes 0, readdata outputs 0. An in-flight memory access is abandoned, and memory must tolerate a dropped strobe.

## Timing
- Reset values: i_readdata=0, d_readdata=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0. Both busywaits follow their requests, so they are 0 when no request is present.
- Arbitration latency: 1 cycle, from the request-sampling edge to a mem strobe visible after that edge.
- Service time: 1 (arbitration) + N (memory busy cycles) + 1 (DONE) cycles.
- Back-to-back requests: minimum gap of one IDLE cycle between grants, so the memory sees its strobe drop for at least one cycle.
- The loser of a tie is granted on the IDLE edge after the winner's DONE cycle.
- mem_busywait is only sampled in GRANT states. Its value elsewhere is ignored.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last-winner register breaks ties: on a simultaneous request, the requester not granted last wins.
  - The register resets to icache-last, so dcache wins the first tie.
  - The register updates on each grant.
- Undefined: fixed dcache priority. icache can starve under continuous dcache traffic; this is accepted for the default build.

## Test plan
- Reset mid-access:
  - Stimulus: i_read=1, address 0x0000010; memory returns after 3 cycles; assert reset during the 2nd busy cycle.
  - Response: mem_read and i_readdata drop to 0 immediately; the FSM restarts from IDLE, and the request is re-granted after reset releases.
- Single icache read:
  - Stimulus: i_read=1, address 0x0000010; memory busy 5 cycles, then returns 128'hA5…A5.
  - Response: mem_read high for 5 cycles with address 0x0000010; i_readdata=A5…A5; i_busywait falls 7 cycles after request; d_busywait stays 0.
- dcache write-back:
  - Stimulus: d_write=1, address 0x0ABCDEF, data 128'h1234….
  - Response: mem_write=1, mem_read=0, mem_writedata matches; d_readdata unchanged.
- Simultaneous requests, macro off:
  - Stimulus: i_read and d_read in the same cycle.
  - Response: dcache is served first; icache is granted on the IDLE edge after DONE_D; i_busywait stays 1 throughout the dcache access.
- Simultaneous requests, macro on, repeated three times:
  - Stimulus: both requesters assert together, three times in succession.
  - Response: grant order D, I, D, I, D, I (alternating, starting with D).
- Input change during grant:
  - Stimulus: change d_address while in GRANT_D.
  - Response: mem_address keeps the latched value until DONE.
